// File: rtl/mul_err_monitor_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
package mul_err_monitor_pkg;
  localparam int ERR_W = 17;
  localparam int ABS_W = 16;
  localparam int SQ_W  = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
endpackage

// File: rtl/mul_err_monitor_if.sv
// Operand, multiplier and result signals of the error monitor; slave is the monitor side.
interface mul_err_monitor_if #(
  parameter int WIN_LOG2 = 8,
  parameter int SUM_W    = 32 + WIN_LOG2
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_a;
  logic [7:0]          in_b;
  logic [7:0]          mul_a;
  logic [7:0]          mul_b;
  logic [15:0]         mul_p;
  logic                out_valid;
  logic                out_ready;
  logic [SUM_W-1:0]    sq_sum;
  logic [15:0]         max_err;
  logic [WIN_LOG2:0]   n_err;

  modport slave (
    input  start, in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, sq_sum, max_err, n_err
  );

  modport master (
    output start, in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, sq_sum, max_err, n_err
  );
endinterface

// File: rtl/mul_err_sq_acc.sv
// Square-and-accumulate stage: registers |err| and err^2, then folds them into the
// window sum, running maximum and nonzero-error count one cycle later.
module mul_err_sq_acc
  import mul_err_monitor_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int SUM_W    = 32 + WIN_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] err,
  output logic                    vld,
  output logic [SUM_W-1:0]        sq_sum,
  output logic [ABS_W-1:0]        max_err,
  output logic [WIN_LOG2:0]       n_err
);
  localparam int NE_W = WIN_LOG2 + 1;

  logic [ABS_W-1:0] mag;
  logic [ABS_W-1:0] mag_q;
  logic [SQ_W-1:0]  sq_q;

  // err spans -65535..65025, so its magnitude always fits in 16 bits.
  assign mag = err[ERR_W-1] ? ABS_W'(-err) : err[ABS_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= 1'b0;
      mag_q   <= '0;
      sq_q    <= '0;
      sq_sum  <= '0;
      max_err <= '0;
      n_err   <= '0;
    end else begin
      vld <= err_vld;
      if (err_vld) begin
        mag_q <= mag;
        sq_q  <= SQ_W'(mag) * SQ_W'(mag);
      end
      if (clr) begin
        sq_sum  <= '0;
        max_err <= '0;
        n_err   <= '0;
      end else if (vld) begin
        sq_sum <= sq_sum + SUM_W'(sq_q);
        if (mag_q > max_err) max_err <= mag_q;
        if (mag_q != '0) n_err <= n_err + NE_W'(1);
      end
    end
  end
endmodule

// File: rtl/mul_err_monitor.sv
// Measures an external 8x8 approximate multiplier against the exact product over a
// window of 2^WIN_LOG2 samples; results are held in REPORT until the consumer takes them.
module mul_err_monitor
  import mul_err_monitor_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int SUM_W    = 32 + WIN_LOG2
) (
  input  logic               clk,
  input  logic               rst,
  mul_err_monitor_if.slave   bus
);
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << WIN_LOG2) - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    rdy;
  logic                    ovld;
  logic                    xfer;
  logic                    clr;
  logic                    v1;
  logic                    v2;
  logic                    v3;
  logic [7:0]              a_q;
  logic [7:0]              b_q;
  logic [15:0]             exact_q;
  logic [15:0]             p_q;
  logic signed [ERR_W-1:0] err;
  logic [SUM_W-1:0]        sq_sum;
  logic [ABS_W-1:0]        max_err;
  logic [WIN_LOG2:0]       n_err;

  assign xfer = bus.in_valid & rdy;
  assign clr  = (state == IDLE) & bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdy   <= 1'b0;
      ovld  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          cnt   <= '0;
          rdy   <= 1'b1;
        end
        RUN: if (xfer) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            rdy   <= 1'b0;
            state <= DRAIN;
          end
        end
        DRAIN: if (!(v1 | v2 | v3)) begin
          state <= REPORT;
          ovld  <= 1'b1;
        end
        REPORT: if (bus.out_ready) begin
          state <= IDLE;
          ovld  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // mul_p is valid while v1 is set, because it is a combinational function of a_q/b_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      exact_q <= '0;
      p_q     <= '0;
    end else begin
      v1 <= xfer;
      v2 <= v1;
      if (xfer) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
      if (v1) begin
        exact_q <= {8'd0, a_q} * {8'd0, b_q};
        p_q     <= bus.mul_p;
      end
    end
  end

  assign err = $signed({1'b0, exact_q}) - $signed({1'b0, p_q});

  mul_err_sq_acc #(.WIN_LOG2(WIN_LOG2), .SUM_W(SUM_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .err_vld (v2),
    .err     (err),
    .vld     (v3),
    .sq_sum  (sq_sum),
    .max_err (max_err),
    .n_err   (n_err)
  );

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ovld;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.sq_sum    = sq_sum;
  assign bus.max_err   = max_err;
  assign bus.n_err     = n_err;
endmodule

// File: tb/tb_mul_err_monitor.sv
// Bench for mul_err_monitor with a 4-sample window: window results predicted from the
// accepted operand pairs and checked by an independent result monitor.
`timescale 1ns/1ps
module tb_mul_err_monitor;
  localparam int WL  = 2;
  localparam int SW  = 34;
  localparam int WIN = 1 << WL;

  typedef struct {
    longint sq;
    longint mx;
    longint n;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   mode;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  logic [7:0]  opa [WIN];
  logic [7:0]  opb [WIN];
  logic [15:0] vpat;
  int          vpat_len;
  logic [15:0] last_ab;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_err_monitor_if #(.WIN_LOG2(WL), .SUM_W(SW)) bus ();

  mul_err_monitor #(.WIN_LOG2(WL), .SUM_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Attached multiplier models: exact, biased, stuck-at-zero, truncated, nonsense.
  function automatic logic [15:0] approx(input int m, input logic [7:0] a, input logic [7:0] b);
    int e;
    e = int'(a) * int'(b);
    case (m)
      0:       return 16'(e);
      1:       return 16'(e - 3);
      2:       return 16'd0;
      3:       return 16'(e + 5);
      4:       return 16'(e) & 16'hFFF0;
      default: return {a, b};
    endcase
  endfunction

  always_comb bus.mul_p = approx(mode, bus.mul_a, bus.mul_b);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int m, input int stall, input bit start_noise);
    longint sq = 0, mx = 0, n = 0, d;
    int idx = 0, k = 0, guard = 0, first = 0, last = 0;
    res_t r;
    mode = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (idx < WIN && guard < 100) begin
      bus.in_valid = (k < vpat_len) ? vpat[k] : 1'b1;
      bus.in_a = opa[idx];
      bus.in_b = opb[idx];
      bus.start = start_noise && (idx == 2);
      @(negedge clk);
      chk("mul_operands_hold", {bus.mul_a, bus.mul_b}, last_ab);
      if (bus.in_valid && bus.in_ready) begin
        d = longint'(opa[idx]) * longint'(opb[idx]) - longint'(approx(m, opa[idx], opb[idx]));
        sq += d * d;
        if (d < 0) d = -d;
        if (d > mx) mx = d;
        if (d != 0) n++;
        if (idx == 0) first = cyc;
        last = cyc;
        last_ab = {opa[idx], opb[idx]};
        idx++;
      end
      k++;
      guard++;
      tick();
    end
    chk("samples_accepted", idx, WIN);
    r.sq = sq; r.mx = mx; r.n = n;
    sb.push_back(r);

    // Keep offering data (and start) while draining: nothing more may be taken.
    bus.in_valid = 1'b1;
    bus.start = start_noise;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_ready_after_full", bus.in_ready, 1'b0);
      tick();
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;

    bus.out_ready = (stall == 0);
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 50) begin
      tick();
      @(negedge clk);
      guard++;
    end
    chk("report_reached", bus.out_valid, 1'b1);
    chk("first_accept_to_valid", cyc - first, (last - first) + 5);
    for (int s = 1; s < stall; s++) tick();
    if (stall > 0) begin
      tick();
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
    end
    tick();
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_after_report_in_ready", bus.in_ready, 1'b0);
      chk("idle_after_report_out_valid", bus.out_valid, 1'b0);
      tick();
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_mul_ab"}, {bus.mul_a, bus.mul_b}, 16'd0);
    chk({tag, "_sq_sum"}, bus.sq_sum, 0);
    chk({tag, "_max_err"}, bus.max_err, 0);
    chk({tag, "_n_err"}, bus.n_err, 0);
  endtask

  // Result monitor: pops a prediction on each handshake, checks holding while stalled.
  initial begin : monitor
    res_t e;
    logic held = 1'b0;
    logic [SW-1:0] h_sq;
    logic [15:0] h_mx;
    logic [WL:0] h_n;
    forever begin
      @(negedge clk);
      if (held) begin
        chk("stall_out_valid_held", bus.out_valid, 1'b1);
        chk("stall_sq_sum_held", bus.sq_sum, h_sq);
        chk("stall_max_err_held", bus.max_err, h_mx);
        chk("stall_n_err_held", bus.n_err, h_n);
      end
      held = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: sq_sum %0d with no window pending", bus.sq_sum);
          end else begin
            e = sb.pop_front();
            chk("sq_sum", bus.sq_sum, e.sq);
            chk("max_err", bus.max_err, e.mx);
            chk("n_err", bus.n_err, e.n);
          end
        end else begin
          held = 1'b1;
          h_sq = bus.sq_sum;
          h_mx = bus.max_err;
          h_n = bus.n_err;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    int acc, g;
    rst = 1'b1;
    mode = 0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    last_ab = '0;
    vpat = '0;
    vpat_len = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");
    tick();

    opa = '{8'd3, 8'd255, 8'd0, 8'd16};
    opb = '{8'd5, 8'd255, 8'd7, 8'd16};
    run_window(0, 0, 1'b0);

    opa = '{8'd2, 8'd2, 8'd2, 8'd2};
    opb = '{8'd2, 8'd2, 8'd2, 8'd2};
    run_window(1, 1, 1'b0);

    opa = '{8'd255, 8'd255, 8'd255, 8'd255};
    opb = '{8'd255, 8'd255, 8'd255, 8'd255};
    run_window(2, 2, 1'b0);

    opa = '{8'd7, 8'd200, 8'd1, 8'd99};
    opb = '{8'd9, 8'd3, 8'd250, 8'd99};
    vpat = 16'b1011001;
    vpat_len = 7;
    run_window(3, 3, 1'b0);
    vpat_len = 0;

    opa = '{8'd11, 8'd0, 8'd128, 8'd1};
    opb = '{8'd13, 8'd0, 8'd2, 8'd1};
    run_window(1, 1, 1'b1);

    // Abort a window after two samples have entered the pipeline.
    mode = 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 8'd9;
    bus.in_b = 8'd9;
    acc = 0;
    g = 0;
    while (acc < 2 && g < 20) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      tick();
      g++;
    end
    chk("abort_accepted_two", acc, 2);
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_ab = '0;
    @(negedge clk);
    check_cleared("abort");
    tick();
    opa = '{8'd2, 8'd2, 8'd2, 8'd2};
    opb = '{8'd2, 8'd2, 8'd2, 8'd2};
    run_window(1, 0, 1'b0);

    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < WIN; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      vpat = 16'($urandom);
      vpat_len = 16;
      run_window(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom));
    end
    vpat_len = 0;

    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
